// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory loader.
//   IMEM_ADDR_W    - instruction memory word-address width
//   IMEM_WORDS     - instruction memory depth in words
//   loader_state_t - loader FSM state encoding
package imem_loader_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int IMEM_WORDS  = 1 << IMEM_ADDR_W;

  typedef enum logic [2:0] {
    ST_LEN  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles four bytes, low byte first, into a 32-bit word.
//   clk, reset      - clock, synchronous active-low reset
//   clear           - return to lane 0 and drop any partial word
//   byte_valid      - a byte is being consumed this cycle
//   byte_data       - the byte
//   word_valid      - this cycle's byte completes a word
//   word            - completed word, valid while word_valid is high
// The fourth byte is folded in combinationally so the owner can act on
// the full word in the same cycle the last byte is accepted.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] partial;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      lane    <= '0;
      partial <= '0;
    end else if (byte_valid) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    partial[7:0]   <= byte_data;
        2'd1:    partial[15:8]  <= byte_data;
        2'd2:    partial[23:16] <= byte_data;
        default: partial        <= partial;
      endcase
    end
  end

  assign word_valid = byte_valid && (lane == 2'd3);
  assign word       = {byte_data, partial};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a framed byte stream into instruction memory and
// holds the CPU in reset until a complete image with a good checksum
// has been written.
//   Frame: N (4 bytes LE), 4*N payload bytes (LE words), 1 checksum byte
//   (sum of payload bytes mod 256).
//   clk, reset          - clock, synchronous active-low reset
//   in_valid/in_ready   - byte stream handshake, in_data carries the byte
//   start               - re-arm pulse, honoured in DONE/ERR only
//   mem_we/addr/wdata   - instruction memory write port, one word per strobe
//   cpu_hold            - 1 keeps the CPU in reset
//   done, error         - image good / length or checksum fault (sticky)
//   words_written       - words committed in the current frame
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [31:0]   WORD_LIMIT = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE_W    = 1;

  loader_state_t state, state_nxt;

  logic            accept;
  logic            restart;
  logic            pk_valid;
  logic            word_valid;
  logic [31:0]     word;
  logic [ADDR_W:0] n_words;
  logic [7:0]      csum;
  logic            last_word;

  assign accept   = in_valid && in_ready;
  assign restart  = start && ((state == ST_DONE) || (state == ST_ERR));
  assign pk_valid = accept && ((state == ST_LEN) || (state == ST_DATA));

  // words_written lags by nothing here: the previous word's count is
  // committed at least three cycles before the next word completes.
  assign last_word = ((words_written + ONE_W) == n_words);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .byte_valid (pk_valid),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LEN: begin
        if (word_valid) begin
          if (word > WORD_LIMIT)  state_nxt = ST_ERR;
          else if (word == 32'd0) state_nxt = ST_CSUM;
          else                    state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_valid && last_word) state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        if (accept) state_nxt = (in_data == csum) ? ST_DONE : ST_ERR;
      end
      ST_DONE, ST_ERR: begin
        if (start) state_nxt = ST_LEN;
      end
      default: state_nxt = ST_LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_LEN;
      in_ready      <= 1'b1;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
      n_words       <= '0;
      csum          <= '0;
    end else begin
      state  <= state_nxt;
      mem_we <= 1'b0;

      // Status outputs are registered from the next state so they change
      // on the same edge as the state itself.
      in_ready <= (state_nxt == ST_LEN) || (state_nxt == ST_DATA) ||
                  (state_nxt == ST_CSUM);
      done     <= (state_nxt == ST_DONE);
      error    <= (state_nxt == ST_ERR);
      cpu_hold <= (state_nxt != ST_DONE);

      if ((state == ST_LEN) && word_valid) n_words <= word[ADDR_W:0];

      if ((state == ST_DATA) && accept) csum <= csum + in_data;

      if ((state == ST_DATA) && word_valid) begin
        mem_we        <= 1'b1;
        mem_addr      <= words_written[ADDR_W-1:0];
        mem_wdata     <= word;
        words_written <= words_written + ONE_W;
      end

      if (restart) begin
        words_written <= '0;
        csum          <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scenarios for imem_loader with hand-computed
// expected writes and status.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        start = 1'b0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [10:0] words_written;

  int checks = 0;
  int errors = 0;

  // write log filled by the monitor
  int          wr_total = 0;
  logic [9:0]  wa [0:63];
  logic [31:0] wd [0:63];

  // two-word frame: header N=2 then payload; payload byte sum = 0xE0
  logic [7:0] s1 [0:11] = '{8'h02, 8'h00, 8'h00, 8'h00,
                            8'h13, 8'h05, 8'h10, 8'h00,
                            8'h93, 8'h05, 8'h20, 8'h00};

  imem_loader #(.ADDR_W(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .start         (start),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .cpu_hold      (cpu_hold),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wa[wr_total[5:0]] <= mem_addr;
      wd[wr_total[5:0]] <= mem_wdata;
      wr_total          <= wr_total + 1;
    end
  end

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b want 1 (byte %h)", in_ready, b);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_written} !==
        {1'b1, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 11'd0}) begin
      errors++;
      $display("FAIL reset_values: rdy=%b we=%b addr=%0d wdata=%h hold=%b done=%b err=%b ww=%0d",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_written);
    end
    reset = 1'b1;
  endtask

  task automatic test_good_frame();
    int base;
    do_reset();
    base = wr_total;
    for (int i = 0; i < 12; i++) begin
      send_byte(s1[i], 1'b0);
      if (i == 7) begin
        checks++;
        if ({mem_we, mem_addr, mem_wdata, words_written} !== {1'b1, 10'd0, 32'h00100513, 11'd1}) begin
          errors++;
          $display("FAIL good_latency: we=%b addr=%0d wdata=%h ww=%0d want 1/0/00100513/1",
                   mem_we, mem_addr, mem_wdata, words_written);
        end
      end
    end
    send_byte(8'hE0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (wr_total - base !== 2) begin
      errors++;
      $display("FAIL good_wcount: writes=%0d want 2", wr_total - base);
    end
    checks++;
    if ({wa[base[5:0]], wd[base[5:0]], wa[base[5:0]+6'd1], wd[base[5:0]+6'd1]} !==
        {10'd0, 32'h00100513, 10'd1, 32'h00200593}) begin
      errors++;
      $display("FAIL good_writes: %0d/%h %0d/%h want 0/00100513 1/00200593",
               wa[base[5:0]], wd[base[5:0]], wa[base[5:0]+6'd1], wd[base[5:0]+6'd1]);
    end
    checks++;
    if ({done, cpu_hold, error, in_ready, words_written} !== {1'b1, 1'b0, 1'b0, 1'b0, 11'd2}) begin
      errors++;
      $display("FAIL good_status: done=%b hold=%b err=%b rdy=%b ww=%0d want 1/0/0/0/2",
               done, cpu_hold, error, in_ready, words_written);
    end
  endtask

  task automatic test_bad_csum();
    int base;
    do_reset();
    base = wr_total;
    for (int i = 0; i < 12; i++) send_byte(s1[i], 1'b0);
    send_byte(8'h31, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ((wr_total - base !== 2) || (wd[base[5:0]] !== 32'h00100513) ||
        (wd[base[5:0]+6'd1] !== 32'h00200593)) begin
      errors++;
      $display("FAIL badcs_writes: writes=%0d d0=%h d1=%h want 2/00100513/00200593",
               wr_total - base, wd[base[5:0]], wd[base[5:0]+6'd1]);
    end
    checks++;
    if ({error, cpu_hold, done, in_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL badcs_status: err=%b hold=%b done=%b rdy=%b want 1/1/0/0",
               error, cpu_hold, done, in_ready);
    end
  endtask

  task automatic test_len_too_big();
    int base;
    do_reset();
    base = wr_total;
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    checks++;
    if ({error, in_ready, cpu_hold, done} !== 4'b1010) begin
      errors++;
      $display("FAIL len1025_status: err=%b rdy=%b hold=%b done=%b want 1/0/1/0",
               error, in_ready, cpu_hold, done);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_total - base !== 0) begin
      errors++;
      $display("FAIL len1025_nowrite: writes=%0d want 0", wr_total - base);
    end
    pulse_start();
    checks++;
    if ({error, in_ready, cpu_hold, done, words_written} !== {4'b0110, 11'd0}) begin
      errors++;
      $display("FAIL err_restart: err=%b rdy=%b hold=%b done=%b ww=%0d want 0/1/1/0/0",
               error, in_ready, cpu_hold, done, words_written);
    end
  endtask

  task automatic test_len_max();
    int base;
    do_reset();
    base = wr_total;
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    checks++;
    if ({error, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL len1024_accept: err=%b rdy=%b want 0/1", error, in_ready);
    end
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hDE, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if ((wr_total - base !== 1) || (wa[base[5:0]] !== 10'd0) || (wd[base[5:0]] !== 32'hDEADBEEF) ||
        (in_ready !== 1'b1) || (done !== 1'b0)) begin
      errors++;
      $display("FAIL len1024_word0: writes=%0d addr=%0d data=%h rdy=%b done=%b want 1/0/deadbeef/1/0",
               wr_total - base, wa[base[5:0]], wd[base[5:0]], in_ready, done);
    end
  endtask

  task automatic test_zero_len();
    int base;
    do_reset();
    base = wr_total;
    for (int i = 0; i < 5; i++) send_byte(8'h00, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if ({done, cpu_hold, error, words_written} !== {3'b100, 11'd0} || (wr_total - base !== 0)) begin
      errors++;
      $display("FAIL zero_done: done=%b hold=%b err=%b ww=%0d writes=%0d want 1/0/0/0/0",
               done, cpu_hold, error, words_written, wr_total - base);
    end
    pulse_start();
    checks++;
    if ({done, cpu_hold, in_ready, error} !== 4'b0110) begin
      errors++;
      $display("FAIL done_restart: done=%b hold=%b rdy=%b err=%b want 0/1/1/0",
               done, cpu_hold, in_ready, error);
    end
  endtask

  task automatic test_stall_start();
    int base;
    do_reset();
    base = wr_total;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) start = 1'b1;
      send_byte(s1[i], 1'b1);
      start = 1'b0;
    end
    send_byte(8'hE0, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if ((wr_total - base !== 2) ||
        ({wa[base[5:0]], wd[base[5:0]], wa[base[5:0]+6'd1], wd[base[5:0]+6'd1]} !==
         {10'd0, 32'h00100513, 10'd1, 32'h00200593})) begin
      errors++;
      $display("FAIL stall_writes: writes=%0d %0d/%h %0d/%h want 2 0/00100513 1/00200593",
               wr_total - base, wa[base[5:0]], wd[base[5:0]], wa[base[5:0]+6'd1], wd[base[5:0]+6'd1]);
    end
    checks++;
    if ({done, cpu_hold, error, words_written} !== {3'b100, 11'd2}) begin
      errors++;
      $display("FAIL stall_status: done=%b hold=%b err=%b ww=%0d want 1/0/0/2",
               done, cpu_hold, error, words_written);
    end
  endtask

  task automatic test_mid_reset();
    int base;
    do_reset();
    base = wr_total;
    for (int i = 0; i < 6; i++) send_byte(s1[i], 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_written} !==
        {1'b1, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 11'd0}) begin
      errors++;
      $display("FAIL midrst_values: rdy=%b we=%b addr=%0d wdata=%h hold=%b done=%b err=%b ww=%0d",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_written);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ((mem_we !== 1'b0) || (wr_total - base !== 0)) begin
      errors++;
      $display("FAIL midrst_nowrite: we=%b writes=%0d want 0/0", mem_we, wr_total - base);
    end
    for (int i = 0; i < 12; i++) send_byte(s1[i], 1'b0);
    send_byte(8'hE0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if ((wr_total - base !== 2) || (wd[base[5:0]] !== 32'h00100513) ||
        (wd[base[5:0]+6'd1] !== 32'h00200593) || (wa[base[5:0]+6'd1] !== 10'd1) ||
        ({done, cpu_hold, error, words_written} !== {3'b100, 11'd2})) begin
      errors++;
      $display("FAIL midrst_replay: writes=%0d d0=%h d1=%h done=%b hold=%b err=%b ww=%0d",
               wr_total - base, wd[base[5:0]], wd[base[5:0]+6'd1], done, cpu_hold, error, words_written);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len_too_big();
    test_len_max();
    test_zero_len();
    test_stall_start();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
